// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: reset stretch, run gating, cycle count, halt and timeout detection for the mips core
module mips_run_ctrl #(
   parameter int RST_HOLD    = 4,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 10000,
   parameter int HALT_REPEAT = 3,
   parameter int AUTO_START  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      pc,
   output logic             core_reset,
   output logic             core_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             done,
   output logic             timeout,
   output logic [31:0]      halt_pc
);
   localparam int HW = $clog2(RST_HOLD + 1);
   localparam int SW = $clog2(HALT_REPEAT + 1);
   typedef enum logic [2:0] {RST, HOLD, IDLE, RUN, DONE, TMO} state_t;
   state_t state, state_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [SW-1:0] same_cnt, same_n, same_inc;
   logic [31:0] prev_pc, prev_n, hpc_n;
   logic [CNT_W-1:0] cnt_n, cnt_inc;
   logic done_n, tmo_n;
   always_comb begin
      state_n  = state;
      hold_n   = hold_cnt;
      same_n   = same_cnt;
      prev_n   = prev_pc;
      cnt_n    = cycle_cnt;
      done_n   = done;
      tmo_n    = timeout;
      hpc_n    = halt_pc;
      cnt_inc  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
      // cycle_cnt is zero only on the first RUN cycle, so it doubles as the first-cycle marker
      same_inc = (pc == prev_pc && cycle_cnt != '0) ? same_cnt + 1'b1 : '0;
      case (state)
         RST: begin
            state_n = HOLD;
            hold_n  = '0;
         end
         HOLD: begin
            hold_n = hold_cnt + 1'b1;
            if (hold_cnt == HW'(RST_HOLD - 1)) begin
               state_n = (AUTO_START != 0) ? RUN : IDLE;
               cnt_n   = '0;
               same_n  = '0;
               prev_n  = '0;
            end
         end
         IDLE: if (start) begin
            state_n = RUN;
            cnt_n   = '0;
            same_n  = '0;
            prev_n  = '0;
         end
         RUN: begin
            cnt_n  = cnt_inc;
            prev_n = pc;
            same_n = same_inc;
            if (same_inc == SW'(HALT_REPEAT)) begin
               state_n = DONE;
               done_n  = 1'b1;
               hpc_n   = pc;
            end else if (TIMEOUT != 0 && cnt_inc == CNT_W'(TIMEOUT)) begin
               state_n = TMO;
               tmo_n   = 1'b1;
            end
         end
         DONE, TMO: if (start) begin
            state_n = HOLD;
            hold_n  = '0;
            done_n  = 1'b0;
            tmo_n   = 1'b0;
            hpc_n   = '0;
            cnt_n   = '0;
         end
         default: state_n = RST;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RST;
         hold_cnt   <= '0;
         same_cnt   <= '0;
         prev_pc    <= '0;
         core_reset <= 1'b1;
         core_en    <= 1'b0;
         cycle_cnt  <= '0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         halt_pc    <= '0;
      end else begin
         state      <= state_n;
         hold_cnt   <= hold_n;
         same_cnt   <= same_n;
         prev_pc    <= prev_n;
         core_reset <= (state_n == RST || state_n == HOLD);
         core_en    <= (state_n == RUN);
         cycle_cnt  <= cnt_n;
         done       <= done_n;
         timeout    <= tmo_n;
         halt_pc    <= hpc_n;
      end
   end
endmodule
